// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg -- shared AES-128 constants, FSM state type and GF(2^8) helper.
//
// Contents:
//   AES_NUM_ROUNDS  round count for AES-128 (10)
//   BLOCK_W         block / key width in bits (128)
//   ROUND_CNT_W     width of the round counter (holds 0..10)
//   GF_REDUCE       low byte of the AES field polynomial 0x11B
//   state_t         engine FSM state encoding (IDLE / ROUND / DONE)
//   xtime()         multiply one GF(2^8) element by x
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam int         BLOCK_W        = 128;
    localparam int         ROUND_CNT_W    = 4;
    localparam logic [7:0] GF_REDUCE      = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8): shift left and fold the carried-out bit back
    // in through the reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// -----------------------------------------------------------------------------
// aes_mix_column -- AES MixColumns applied to a single 32-bit column.
//
// Ports:
//   col    input  [31:0]  column bytes, row 0 in [31:24] .. row 3 in [7:0]
//   mixed  output [31:0]  column multiplied by the circulant {02 03 01 01}
// -----------------------------------------------------------------------------
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // {03}.b is written as xtime(b) ^ b.
    assign mixed[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mixed[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mixed[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mixed[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/sbox_LUT.sv
// -----------------------------------------------------------------------------
// sbox_LUT -- AES forward S-box as a 256-entry lookup table.
//
// Ports:
//   in_byte   input  [7:0]  byte to substitute
//   out_byte  output [7:0]  SubBytes(in_byte)
// -----------------------------------------------------------------------------
module sbox_LUT (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 is the leftmost byte, so row n of the usual 16x16 table is the
    // n-th 128-bit word below.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_round_engine.sv
// -----------------------------------------------------------------------------
// aes_round_engine -- iterative AES-128 encryptor, one round per clock.
//
// Ports:
//   clk         input            rising-edge clock
//   rst_n       input            asynchronous active-low reset
//   in_valid    input            plaintext / aes_key valid
//   in_ready    output           engine idle and able to accept a block
//   plaintext   input  [127:0]   block to encrypt, byte 0 in [127:120]
//   aes_key     input  [127:0]   cipher key (round key 0)
//   round_keys  input  [1279:0]  round keys 1..10, key k in [128k-1 -: 128]
//   out_valid   output           ciphertext valid
//   out_ready   input            downstream accepts ciphertext
//   ciphertext  output [127:0]   encrypted block
//   busy        output           high while a block is in flight
//
// Timing: accept edge loads plaintext ^ aes_key, the next ten edges perform
// rounds 1..10 (the tenth writes ciphertext), then DONE holds the result
// until out_ready. Steady-state throughput is one block per 12 cycles.
// -----------------------------------------------------------------------------
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BLOCK_W-1:0]            plaintext,
    input  logic [BLOCK_W-1:0]            aes_key,
    input  logic [BLOCK_W*NUM_ROUNDS-1:0] round_keys,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK_W-1:0]            ciphertext,
    output logic                          busy
);

    state_t                   fsm;
    logic [ROUND_CNT_W-1:0]   round_cnt;
    logic [BLOCK_W-1:0]       blk_state;

    logic [7:0]               sub_bytes [16];
    logic [BLOCK_W-1:0]       shifted;
    logic [BLOCK_W-1:0]       mixed;
    logic [BLOCK_W-1:0]       key_sched [16];
    logic [ROUND_CNT_W-1:0]   key_idx;
    logic [BLOCK_W-1:0]       round_key;
    logic [BLOCK_W-1:0]       round_out;
    logic                     last_round;

    // ---------------- SubBytes: one S-box per state byte ----------------
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sbox_LUT u_sbox (
            .in_byte  (blk_state[BLOCK_W-1-8*i -: 8]),
            .out_byte (sub_bytes[i])
        );
    end

    // ---------------- ShiftRows: row r rotates left by r ----------------
    // Byte index i = row + 4*column, so output (r,c) takes input (r,c+r mod 4).
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign shifted[BLOCK_W-1-8*(r+4*c) -: 8] = sub_bytes[r + 4*((c + r) % 4)];
        end
    end

    // ---------------- MixColumns ----------------
    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mix_column u_mix (
            .col   (shifted[BLOCK_W-1-32*c -: 32]),
            .mixed (mixed[BLOCK_W-1-32*c -: 32])
        );
    end

    // ---------------- Round key select ----------------
    // Pad the table to the counter's full range so every index is in bounds;
    // unused entries are never selected while a block is in flight.
    for (genvar k = 0; k < 16; k++) begin : g_key
        if (k < NUM_ROUNDS) begin : g_used
            assign key_sched[k] = round_keys[BLOCK_W*k +: BLOCK_W];
        end else begin : g_pad
            assign key_sched[k] = '0;
        end
    end

    assign key_idx    = round_cnt - ROUND_CNT_W'(1);
    assign round_key  = key_sched[key_idx];
    assign last_round = (round_cnt == ROUND_CNT_W'(NUM_ROUNDS));
    assign round_out  = (last_round ? shifted : mixed) ^ round_key;

    // ---------------- Control ----------------
    // NOTE: every register here uses nonblocking assignment so all of them
    // sample the pre-edge values, and the datapath registers are cleared on
    // reset too so an aborted block leaves no trace of plaintext or key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= ST_IDLE;
            round_cnt  <= '0;
            blk_state  <= '0;
            ciphertext <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_state <= plaintext ^ aes_key;
                        round_cnt <= ROUND_CNT_W'(1);
                        fsm       <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (last_round) begin
                        ciphertext <= round_out;
                        round_cnt  <= '0;
                        fsm        <= ST_DONE;
                    end else begin
                        blk_state <= round_out;
                        round_cnt <= round_cnt + ROUND_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == ST_IDLE);
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm != ST_IDLE);

endmodule

// File: tb/tb_aes_round_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_round_engine -- scoreboard bench for aes_round_engine.
//
// Accepted blocks are encrypted by a byte-array AES model (S-box derived from
// the GF(2^8) inverse plus affine map, key schedule computed here) and the
// expected ciphertext is queued; a negedge monitor pops and compares on every
// output handshake and also checks latency and output stability.
// -----------------------------------------------------------------------------
module tb_aes_round_engine;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [127:0]    plaintext;
    logic [127:0]    aes_key;
    logic [1279:0]   round_keys;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    ciphertext;
    logic            busy;

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .aes_key    (aes_key),
        .round_keys (round_keys),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1279:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1279:0] rk;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 1; k <= 10; k++)
            rk[128*(k-1) +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [7:0]    a [4];
        logic [1279:0] rks;
        logic [127:0]  rk;
        logic [127:0]  res;
        rks = expand(key);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = s[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = gmul(8'h02, a[j]) ^ gmul(8'h03, a[(j+1)%4])
                                   ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end else begin
                s = t;
            end
            rk = rks[128*(rnd-1) +: 128];
            for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];
    int           acc_edges [$];
    int           acc_edge;
    bit           waiting = 1'b0;
    bit           have_prev = 1'b0;
    logic [127:0] prev_ct;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            waiting   = 1'b0;
            have_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(encrypt(plaintext, aes_key));
                acc_edge = cyc + 1;
                acc_edges.push_back(acc_edge);
                waiting = 1'b1;
            end
            if (out_valid) begin
                if (waiting) begin
                    // Acceptance edge counted as the first of the edges.
                    check("latency_edges", 128'(cyc - acc_edge + 1), 128'(11));
                    waiting = 1'b0;
                end
                if (have_prev) check("ct_stable", ciphertext, prev_ct);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 128'(1), 128'(0));
                    end else begin
                        check("ciphertext", ciphertext, exp_q.pop_front());
                    end
                    got_q.push_back(ciphertext);
                    n_out++;
                    have_prev = 1'b0;
                end else begin
                    prev_ct   = ciphertext;
                    have_prev = 1'b1;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        @(posedge clk); #1;
        plaintext  = pt;
        aes_key    = key;
        round_keys = expand(key);
        in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        for (int i = 0; i < 200 && n_out < target; i++) @(negedge clk);
        check("out_count", 128'(n_out), 128'(target));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check("out_valid_seen", 128'(out_valid), 128'(1));
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] pt_r;
        logic [127:0] key_r;
        int           base;

        rst_n      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        plaintext  = '0;
        aes_key    = '0;
        round_keys = '0;
        build_sbox();

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready",   128'(in_ready),  128'(1));
        check("rst_out_valid",  128'(out_valid), 128'(0));
        check("rst_busy",       128'(busy),      128'(0));
        check("rst_ciphertext", ciphertext,      128'(0));
        @(posedge clk); #2 rst_n = 1'b1;

        // FIPS-197 Appendix B and C.1
        send(PT_B, KEY_B);
        wait_out(n_out + 1);
        check("fips_b", got_q[$], CT_B);
        send(PT_C, KEY_C);
        wait_out(n_out + 1);
        check("fips_c1", got_q[$], CT_C);

        // Backpressure: 20 cycles with out_ready low
        out_ready = 1'b0;
        send(128'({$urandom, $urandom, $urandom, $urandom}),
             128'({$urandom, $urandom, $urandom, $urandom}));
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        base = n_out;
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready",  128'(in_ready),  128'(1));
        check("bp_idle_out_valid", 128'(out_valid), 128'(0));
        check("bp_one_out",        128'(n_out),     128'(base + 1));

        // Ignored input while busy (ROUND and DONE)
        pt_r  = 128'({$urandom, $urandom, $urandom, $urandom});
        key_r = 128'({$urandom, $urandom, $urandom, $urandom});
        out_ready = 1'b0;
        send(pt_r, key_r);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            plaintext = 128'({$urandom, $urandom, $urandom, $urandom});
            in_valid  = 1'($urandom & 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_out(n_out + 1);
        check("ignored_input", got_q[$], encrypt(pt_r, key_r));

        // Reset during round 5 aborts the block
        base = n_out;
        send(PT_C, KEY_C);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",       128'(busy),      128'(0));
        check("abort_out_valid",  128'(out_valid), 128'(0));
        check("abort_in_ready",   128'(in_ready),  128'(1));
        check("abort_ciphertext", ciphertext,      128'(0));
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_valid", 128'(out_valid), 128'(0));
        end
        check("abort_no_output", 128'(n_out), 128'(base));
        send(PT_C, KEY_C);
        wait_out(base + 1);
        check("post_reset_c1", got_q[$], CT_C);

        // Back-to-back with in_valid held high and out_ready tied high
        base = n_out;
        @(posedge clk); #1;
        plaintext  = PT_B;
        aes_key    = KEY_B;
        round_keys = expand(KEY_B);
        in_valid   = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        plaintext  = PT_C;
        aes_key    = KEY_C;
        round_keys = expand(KEY_C);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(base + 2);
        check("b2b_first",   got_q[$-1], CT_B);
        check("b2b_second",  got_q[$],   CT_C);
        check("b2b_spacing", 128'(acc_edges[$] - acc_edges[$-1]), 128'(12));

        // Randomized blocks with random output stalls
        for (int n = 0; n < 6; n++) begin
            out_ready = 1'b0;
            base = n_out;
            send(128'({$urandom, $urandom, $urandom, $urandom}),
                 128'({$urandom, $urandom, $urandom, $urandom}));
            wait_valid();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_out(base + 1);
        end

        @(posedge clk); #1;
        check("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
